jk_cmd_arbiter: RTL and testbench

JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

---
 rtl/jk_pkg.sv | 20 ++
 rtl/jk_cell.sv | 27 ++
 rtl/jk_cmd_arbiter.sv | 116 +++++++++++
 tb/tb_jk_cmd_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK command arbiter: op codes, FSM encoding and
// the default command-count width.
package jk_pkg;

   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_RESET  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/jk_cell.sv
// JK storage element: standard JK next-state on every rising edge,
// cleared by the asynchronous active-low reset.
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qn
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   assign qn = ~q;

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Two-requester round-robin arbiter that executes timed JK operations:
// each accepted command drives j/k for cnt cycles, then pulses done.
module jk_cmd_arbiter
   import jk_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [1:0]       i_req0_op,
   input  logic [CNT_W-1:0] i_req0_cnt,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [1:0]       i_req1_op,
   input  logic [CNT_W-1:0] i_req1_cnt,
   output logic             o_j,
   output logic             o_k,
   output logic             o_q,
   output logic             o_qn,
   output logic             o_busy,
   output logic             o_grant,
   output logic             o_done
);

   state_e           state_reg, state_next;
   op_e              op_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             grant_reg;
   logic             prio_reg;

   logic             winner;
   logic             accept;
   logic [1:0]       win_op;
   logic [CNT_W-1:0] win_cnt;

   // prio_reg names the requester that wins a tie; a lone requester always wins.
   always_comb begin
      winner = prio_reg;
      if (i_req0_valid && !i_req1_valid) begin
         winner = 1'b0;
      end else if (!i_req0_valid && i_req1_valid) begin
         winner = 1'b1;
      end
      accept  = (state_reg == ST_IDLE) && i_rst_n && (i_req0_valid || i_req1_valid);
      win_op  = winner ? i_req1_op  : i_req0_op;
      win_cnt = winner ? i_req1_cnt : i_req0_cnt;
   end

   assign o_req0_ready = accept && !winner;
   assign o_req1_ready = accept && winner;
   assign o_grant      = grant_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_reg    <= OP_HOLD;
         cnt_reg   <= '0;
         grant_reg <= 1'b0;
         prio_reg  <= 1'b0;
      end else if (accept) begin
         op_reg    <= op_e'(win_op);
         cnt_reg   <= (win_cnt == '0) ? CNT_W'(1) : win_cnt;
         grant_reg <= winner;
         prio_reg  <= ~winner;
      end else if (state_reg == ST_EXEC) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = ST_EXEC;
         ST_EXEC: if (cnt_reg == CNT_W'(1)) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_j    = 1'b0;
      o_k    = 1'b0;
      o_busy = 1'b0;
      o_done = 1'b0;
      case (state_reg)
         ST_EXEC: begin
            {o_j, o_k} = op_reg;
            o_busy     = 1'b1;
         end
         ST_DONE: begin
            o_busy = 1'b1;
            o_done = 1'b1;
         end
         default: ;
      endcase
   end

   jk_cell u_cell (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .j     (o_j),
      .k     (o_k),
      .q     (o_q),
      .qn    (o_qn)
   );

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Randomized bench: a command-level model predicts grants, q trajectory and
// completion times; a monitor scores each o_done pulse against a queue.
module tb_jk_cmd_arbiter;
   import jk_pkg::*;

   localparam int CNT_W = 4;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_req0_valid = 1'b0, i_req1_valid = 1'b0;
   logic             o_req0_ready, o_req1_ready;
   logic [1:0]       i_req0_op = '0, i_req1_op = '0;
   logic [CNT_W-1:0] i_req0_cnt = '0, i_req1_cnt = '0;
   logic             o_j, o_k, o_q, o_qn, o_busy, o_grant, o_done;

   jk_cmd_arbiter #(.CNT_W(CNT_W)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req0_valid (i_req0_valid),
      .o_req0_ready (o_req0_ready),
      .i_req0_op    (i_req0_op),
      .i_req0_cnt   (i_req0_cnt),
      .i_req1_valid (i_req1_valid),
      .o_req1_ready (o_req1_ready),
      .i_req1_op    (i_req1_op),
      .i_req1_cnt   (i_req1_cnt),
      .o_j          (o_j),
      .o_k          (o_k),
      .o_q          (o_q),
      .o_qn         (o_qn),
      .o_busy       (o_busy),
      .o_grant      (o_grant),
      .o_done       (o_done)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct packed {
      logic grant;
      logic q;
      int   done_cyc;
   } exp_t;
   exp_t exp_q[$];

   // Pending request per requester, as the requester sees it.
   logic             pend[2];
   logic [1:0]       p_op[2];
   logic [CNT_W-1:0] p_cnt[2];
   bit               gen_en;

   // Command-level model state.
   int         m_acc, m_eff, m_free_at;
   logic [1:0] m_op;
   logic       m_q0, m_pref;

   // q after applying op n times starting from q.
   function automatic logic apply_n(input logic [1:0] op, input logic q, input int n);
      if (n == 0) return q;
      case (op)
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return q ^ n[0];
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] rand_cnt();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return CNT_W'(15);
         default: return CNT_W'($urandom_range(1, 15));
      endcase
   endfunction

   task automatic model_reset();
      m_acc = -100; m_eff = 0; m_free_at = 0;
      m_op = 2'b00; m_q0 = 1'b0; m_pref = 1'b0;
      exp_q.delete();
   endtask

   // One cycle: update requesters, drive, check against model, advance.
   task automatic step();
      logic idle, any, w, q_now;
      logic [1:0] jk_now;
      int k, eff;
      for (int r = 0; r < 2; r++) begin
         if (gen_en && !pend[r] && $urandom_range(0, 3) == 0) begin
            pend[r] = 1'b1; p_op[r] = 2'($urandom_range(0, 3)); p_cnt[r] = rand_cnt();
         end else if (pend[r] && cyc < m_free_at && $urandom_range(0, 2) == 0) begin
            p_op[r] = 2'($urandom_range(0, 3)); p_cnt[r] = rand_cnt();
         end
      end
      i_req0_valid = pend[0]; i_req0_op = p_op[0]; i_req0_cnt = p_cnt[0];
      i_req1_valid = pend[1]; i_req1_op = p_op[1]; i_req1_cnt = p_cnt[1];
      #1;
      idle = (cyc >= m_free_at);
      any  = pend[0] || pend[1];
      w    = (pend[0] && pend[1]) ? m_pref : pend[1];
      check("ready0", o_req0_ready, idle && any && !w);
      check("ready1", o_req1_ready, idle && any && w);
      k = cyc - m_acc;
      if (k >= 1 && k <= m_eff) begin
         q_now = apply_n(m_op, m_q0, k - 1); jk_now = m_op;
      end else begin
         q_now = apply_n(m_op, m_q0, m_eff); jk_now = 2'b00;
      end
      check("q", o_q, q_now);
      check("qn", o_qn, !q_now);
      check("jk", {o_j, o_k}, jk_now);
      check("busy", o_busy, (k >= 1 && k <= m_eff + 1));
      if (idle && any) begin
         eff       = (p_cnt[w] == '0) ? 1 : int'(p_cnt[w]);
         m_q0      = apply_n(m_op, m_q0, m_eff);
         m_op      = p_op[w];
         m_eff     = eff;
         m_acc     = cyc;
         m_free_at = cyc + eff + 2;
         m_pref    = !w;
         exp_q.push_back('{grant: w, q: apply_n(m_op, m_q0, eff), done_cyc: cyc + eff + 1});
         pend[w]   = 1'b0;
      end
      @(negedge i_clk);
   endtask

   // Monitor: score every completion pulse against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         #2;
         if (i_rst_n) begin
            if (o_done) begin
               if (exp_q.size() == 0) begin
                  check("done_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("done_cycle", cyc, e.done_cyc);
                  check("done_grant", o_grant, e.grant);
                  check("done_q", o_q, e.q);
                  $display("done: grant=%0d q=%0d cycle=%0d", o_grant, o_q, cyc);
               end
            end else if (exp_q.size() > 0 && exp_q[0].done_cyc <= cyc) begin
               check("done_missing", 0, 1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic drain();
      gen_en = 0;
      for (int i = 0; i < 300 && (pend[0] || pend[1] || cyc < m_free_at); i++) step();
      check("drain_timeout", (pend[0] || pend[1] || cyc < m_free_at), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_q"}, o_q, 0);
      check({tag, "_qn"}, o_qn, 1);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_grant"}, o_grant, 0);
      check({tag, "_jk"}, {o_j, o_k}, 0);
      check({tag, "_rdy"}, {o_req0_ready, o_req1_ready}, 0);
   endtask

   task automatic preset_contest();
      pend[0] = 1'b1; p_op[0] = OP_SET;   p_cnt[0] = CNT_W'(1);
      pend[1] = 1'b1; p_op[1] = OP_RESET; p_cnt[1] = CNT_W'(1);
   endtask

   initial begin
      model_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      p_op[0] = '0; p_op[1] = '0; p_cnt[0] = '0; p_cnt[1] = '0;
      gen_en = 0;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      repeat (2) @(negedge i_clk);
      #1;
      check_reset_outputs("rst");
      @(negedge i_clk);

      preset_contest();
      i_rst_n = 1'b1;
      gen_en = 1;
      repeat (400) step();
      drain();

      // Abort a long toggle command in its third EXEC cycle.
      pend[0] = 1'b1; p_op[0] = OP_TOGGLE; p_cnt[0] = CNT_W'(8);
      step();
      for (int i = 0; i < 20 && cyc < m_acc + 3; i++) step();
      check("abort_busy_before", o_busy, 1);
      i_rst_n = 1'b0;
      i_req0_valid = 1'b1; i_req1_valid = 1'b1;
      #1;
      check_reset_outputs("abort");
      model_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      repeat (2) begin
         @(negedge i_clk);
         #1;
         check_reset_outputs("abort_hold");
      end
      @(negedge i_clk);

      preset_contest();
      i_rst_n = 1'b1;
      gen_en = 1;
      repeat (300) step();
      drain();
      repeat (3) @(negedge i_clk);
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
